// File: rtl/llsc_monitor.sv
// Multi-channel LL/SC reservation monitor: one granule reservation per channel with
// snoop kill, flush and lifetime timeout, plus a same-cycle SC verdict and forwarded LLbit.
module llsc_monitor #(
  parameter  int NUM_CH    = 4,
  parameter  int ADDR_W    = 32,
  parameter  int GRAN_LOG2 = 4,
  parameter  int TIMEOUT   = 1023,
  localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] flush,
  input  logic              ll_we,
  input  logic [CH_W-1:0]   ll_ch,
  input  logic [ADDR_W-1:0] ll_addr,
  input  logic              sc_req,
  input  logic [CH_W-1:0]   sc_ch,
  input  logic [ADDR_W-1:0] sc_addr,
  output logic              sc_ok,
  input  logic              st_valid,
  input  logic [CH_W-1:0]   st_ch,
  input  logic [ADDR_W-1:0] st_addr,
  output logic [NUM_CH-1:0] llbit_o
);

  localparam int GW    = ADDR_W - GRAN_LOG2;
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(TIMEOUT);

  logic [NUM_CH-1:0] valid_q, valid_d;
  logic [GW-1:0]     raddr_q [NUM_CH];
  logic [GW-1:0]     raddr_d [NUM_CH];
  logic [CNT_W-1:0]  cnt_q   [NUM_CH];
  logic [CNT_W-1:0]  cnt_d   [NUM_CH];

  logic [GW-1:0] ll_gran, sc_gran, st_gran;
  logic          ll_in, sc_in, st_in;
  logic          sel_valid, sel_match, sel_flush, snoop_kill;

  // Byte offsets within a granule never take part in a compare.
  logic unused_low;
  assign unused_low = ^{ll_addr[GRAN_LOG2-1:0], sc_addr[GRAN_LOG2-1:0], st_addr[GRAN_LOG2-1:0]};

  function automatic logic ch_in_range(input logic [CH_W-1:0] ch);
    return 32'(ch) < NUM_CH;
  endfunction

  assign ll_gran = ll_addr[ADDR_W-1:GRAN_LOG2];
  assign sc_gran = sc_addr[ADDR_W-1:GRAN_LOG2];
  assign st_gran = st_addr[ADDR_W-1:GRAN_LOG2];
  assign ll_in   = ll_we    && ch_in_range(ll_ch);
  assign sc_in   = sc_req   && ch_in_range(sc_ch);
  assign st_in   = st_valid && ch_in_range(st_ch);

  // Select the SC channel's current state; an out-of-range index selects nothing.
  always_comb begin
    sel_valid = 1'b0;
    sel_match = 1'b0;
    sel_flush = 1'b0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (sc_ch == CH_W'(c)) begin
        sel_valid = valid_q[c];
        sel_match = (raddr_q[c] == sc_gran);
        sel_flush = flush[c];
      end
    end
  end

  // A foreign store to the same granule in the SC cycle is ordered ahead of the SC.
  assign snoop_kill = st_in && (st_ch != sc_ch) && (st_gran == sc_gran);

  assign sc_ok = !rst && sc_in && sel_valid && sel_match && !sel_flush && !snoop_kill;

  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      valid_d[c] = valid_q[c];
      raddr_d[c] = raddr_q[c];
      cnt_d[c]   = cnt_q[c];
      if (flush[c]) begin
        valid_d[c] = 1'b0;
      end else if (ll_in && ll_ch == CH_W'(c)) begin
        valid_d[c] = 1'b1;
        raddr_d[c] = ll_gran;
        cnt_d[c]   = CNT_LOAD;
      end else if (sc_in && sc_ch == CH_W'(c)) begin
        valid_d[c] = 1'b0;
      end else if (st_in && st_ch != CH_W'(c) && st_gran == raddr_q[c]) begin
        valid_d[c] = 1'b0;
      end else if ((TIMEOUT != 0) && valid_q[c] && cnt_q[c] == '0) begin
        valid_d[c] = 1'b0;
      end else if (valid_q[c] && cnt_q[c] != '0) begin
        cnt_d[c] = cnt_q[c] - 1'b1;
      end
    end
  end

  assign llbit_o = rst ? '0 : valid_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        raddr_q[c] <= '0;
        cnt_q[c]   <= '0;
      end
    end else begin
      valid_q <= valid_d;
      for (int c = 0; c < NUM_CH; c++) begin
        raddr_q[c] <= raddr_d[c];
        cnt_q[c]   <= cnt_d[c];
      end
    end
  end

endmodule

// File: tb/tb_llsc_monitor.sv
// Directed bench for llsc_monitor (NUM_CH=4, 16-byte granule, TIMEOUT=8).
module tb_llsc_monitor;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  flush = '0;
  logic        ll_we = 1'b0;
  logic [1:0]  ll_ch = '0;
  logic [31:0] ll_addr = '0;
  logic        sc_req = 1'b0;
  logic [1:0]  sc_ch = '0;
  logic [31:0] sc_addr = '0;
  logic        sc_ok;
  logic        st_valid = 1'b0;
  logic [1:0]  st_ch = '0;
  logic [31:0] st_addr = '0;
  logic [3:0]  llbit_o;

  int n_vec = 0;
  int n_err = 0;

  llsc_monitor #(.NUM_CH(4), .ADDR_W(32), .GRAN_LOG2(4), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .ll_we(ll_we), .ll_ch(ll_ch), .ll_addr(ll_addr),
    .sc_req(sc_req), .sc_ch(sc_ch), .sc_addr(sc_addr), .sc_ok(sc_ok),
    .st_valid(st_valid), .st_ch(st_ch), .st_addr(st_addr),
    .llbit_o(llbit_o)
  );

  always #5 clk = ~clk;

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge and return all request inputs to idle.
  task automatic tick();
    @(posedge clk);
    #1;
    flush = '0; ll_we = 1'b0; sc_req = 1'b0; st_valid = 1'b0;
  endtask

  task automatic set_ll(input int ch, input logic [31:0] a);
    ll_we = 1'b1; ll_ch = 2'(ch); ll_addr = a;
  endtask

  task automatic set_sc(input int ch, input logic [31:0] a);
    sc_req = 1'b1; sc_ch = 2'(ch); sc_addr = a;
  endtask

  task automatic set_st(input int ch, input logic [31:0] a);
    st_valid = 1'b1; st_ch = 2'(ch); st_addr = a;
  endtask

  initial begin
    // Reset held: outputs forced low even with requests present.
    set_ll(0, 32'h1000); set_sc(0, 32'h1000);
    #1;
    check_vec("rst_llbit", 32'(llbit_o), 32'h0);
    check_vec("rst_scok",  32'(sc_ok),   32'h0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0; ll_we = 1'b0; sc_req = 1'b0;
    #1;
    check_vec("post_rst_llbit", 32'(llbit_o), 32'h0);
    tick();

    // Basic LL then SC in the same granule.
    set_ll(0, 32'h1000); #1;
    check_vec("ll0_llbit", 32'(llbit_o), 32'h1);
    tick(); #1;
    check_vec("ll0_hold", 32'(llbit_o), 32'h1);
    tick();
    set_sc(0, 32'h100C); #1;
    check_vec("sc0_ok",    32'(sc_ok),   32'h1);
    check_vec("sc0_llbit", 32'(llbit_o), 32'h0);
    tick();

    // Address mismatch.
    set_ll(1, 32'h2000); tick();
    set_sc(1, 32'h2010); #1;
    check_vec("mis_scok",  32'(sc_ok),   32'h0);
    check_vec("mis_llbit", 32'(llbit_o), 32'h0);
    tick();
    set_sc(1, 32'h2000); #1;
    check_vec("mis_retry", 32'(sc_ok), 32'h0);
    tick();

    // Cross-channel kill versus own store.
    set_ll(0, 32'h3000); tick();
    set_st(2, 32'h3008); #1;
    check_vec("kill_llbit", 32'(llbit_o), 32'h0);
    tick();
    set_sc(0, 32'h3000); #1;
    check_vec("kill_scok", 32'(sc_ok), 32'h0);
    tick();
    set_ll(0, 32'h3000); tick();
    set_st(0, 32'h3008); #1;
    check_vec("own_st_llbit", 32'(llbit_o), 32'h1);
    tick();
    set_sc(0, 32'h3000); #1;
    check_vec("own_st_scok", 32'(sc_ok), 32'h1);
    tick();

    // Same-cycle foreign store to the SC granule.
    set_ll(0, 32'h3000); tick();
    set_sc(0, 32'h3000); set_st(1, 32'h3004); #1;
    check_vec("snoop_scok", 32'(sc_ok), 32'h0);
    tick();

    // SC + flush + foreign store together.
    set_ll(0, 32'h4000); tick();
    set_sc(0, 32'h4000); flush = 4'b0001; set_st(3, 32'h4000); #1;
    check_vec("simul_scok",  32'(sc_ok),   32'h0);
    check_vec("simul_llbit", 32'(llbit_o), 32'h0);
    tick();

    // Flush alone kills an otherwise passing reservation.
    set_ll(0, 32'h4800); tick();
    set_sc(0, 32'h4800); flush = 4'b0001; #1;
    check_vec("flush_scok", 32'(sc_ok), 32'h0);
    tick();

    // LL beats a same-cycle foreign store to its granule.
    set_ll(1, 32'h5000); set_st(0, 32'h5000); #1;
    check_vec("ll_vs_st", 32'(llbit_o), 32'h2);
    tick(); #1;
    check_vec("ll_vs_st_hold", 32'(llbit_o), 32'h2);
    flush = 4'b0010; #1;
    check_vec("flush1_llbit", 32'(llbit_o), 32'h0);
    tick();

    // SC judged on old state while LL on same channel reloads.
    set_ll(2, 32'h6000); tick();
    set_ll(2, 32'h7000); set_sc(2, 32'h6000); #1;
    check_vec("sc_ll_scok",  32'(sc_ok),   32'h1);
    check_vec("sc_ll_llbit", 32'(llbit_o), 32'h4);
    tick();
    set_sc(2, 32'h7000); #1;
    check_vec("reload_scok", 32'(sc_ok), 32'h1);
    tick();

    // Timeout: SC at cycle 9 still passes.
    set_ll(3, 32'h8000); tick();
    for (int i = 1; i < 9; i++) tick();
    set_sc(3, 32'h8000); #1;
    check_vec("to_c9_scok", 32'(sc_ok), 32'h1);
    tick();

    // Timeout: llbit falls in cycle 9, SC at cycle 10 fails.
    set_ll(3, 32'h8000); tick();
    for (int i = 1; i < 8; i++) tick();
    #1;
    check_vec("to_c8_llbit", 32'(llbit_o), 32'h8);
    tick(); #1;
    check_vec("to_c9_llbit", 32'(llbit_o), 32'h0);
    tick();
    set_sc(3, 32'h8000); #1;
    check_vec("to_c10_scok", 32'(sc_ok), 32'h0);
    tick();

    // Asynchronous reset mid-operation.
    for (int c = 0; c < 4; c++) begin
      set_ll(c, 32'h9000 + 32'(c) * 32'h100);
      tick();
    end
    #1;
    check_vec("all_llbit", 32'(llbit_o), 32'hF);
    set_sc(0, 32'h9000);
    #1;
    check_vec("pre_arst_scok", 32'(sc_ok), 32'h1);
    rst = 1'b1; #1;
    check_vec("arst_llbit", 32'(llbit_o), 32'h0);
    check_vec("arst_scok",  32'(sc_ok),   32'h0);
    #1; rst = 1'b0; sc_req = 1'b0; #1;
    check_vec("arst_rel_llbit", 32'(llbit_o), 32'h0);
    for (int c = 0; c < 4; c++) begin
      set_sc(c, 32'h9000 + 32'(c) * 32'h100); #1;
      check_vec($sformatf("arst_sc%0d", c), 32'(sc_ok), 32'h0);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
